// File: rtl/sev_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   seg_t          : segment vector a..g, a at index 0, 1 = lit (active-high)
//   SEG_BLANK      : all segments dark
//   HEX_SEG_TABLE  : hex digit 0..F to segment pattern
//   hex2seg()      : table lookup helper
package sev_pkg;

   typedef logic [0:6] seg_t;

   localparam seg_t SEG_BLANK = 7'b0000000;

   // Literals read left to right as a..g because seg_t is [0:6].
   localparam seg_t HEX_SEG_TABLE [16] = '{
      7'b1111110,  // 0
      7'b0110000,  // 1
      7'b1101101,  // 2
      7'b1111001,  // 3
      7'b0110011,  // 4
      7'b1011011,  // 5
      7'b1011111,  // 6
      7'b1110000,  // 7
      7'b1111111,  // 8
      7'b1110011,  // 9
      7'b1110111,  // A
      7'b0011111,  // b
      7'b1001110,  // C
      7'b0111101,  // d
      7'b1001111,  // E
      7'b1000111   // F
   };

   function automatic seg_t hex2seg(input logic [3:0] nibble);
      return HEX_SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/sev_seg_scan_driver_lut.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : segments a..g, active-high
module hex_seg_lut
   import sev_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   assign seg = hex2seg(nibble);

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment display driver.
// Latches a packed hex value, scans one digit per refresh slot with a guard
// interval at the start of each slot, optional leading-zero blanking, and
// swaps in newly loaded data only at frame boundaries so a frame never tears.
//   CLK, RST    : clock, synchronous active-high reset
//   ENABLE      : scan enable; when low the scan position holds, pins go dark
//   LOAD        : strobe capturing VALUE, DP_IN, BLANK_LZ
//   VALUE       : packed nibbles, digit 0 in [3:0]
//   DP_IN       : per-digit decimal point, 1 = lit
//   BLANK_LZ    : leading-zero blanking enable
//   SEV, DP     : segment and decimal point pins (pin polarity)
//   AN          : digit select pins (pin polarity)
//   DIGIT_IDX   : digit currently driven
//   FRAME_DONE  : one-cycle pulse after the scan wraps to digit 0
module sev_seg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int GUARD_CYCLES   = 1,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    ENABLE,
   input  logic                    LOAD,
   input  logic [4*NUM_DIGITS-1:0] VALUE,
   input  logic [NUM_DIGITS-1:0]   DP_IN,
   input  logic                    BLANK_LZ,
   output logic [0:6]              SEV,
   output logic                    DP,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] DIGIT_IDX,
   output logic                    FRAME_DONE
);

   import sev_pkg::*;

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
   localparam logic [PRE_W-1:0] GUARD_END = PRE_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

   localparam logic [0:6]            SEG_OFF_PIN = {7{SEG_INV}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF_PIN  = {NUM_DIGITS{AN_INV}};

   logic [PRE_W-1:0]        prescaler;
   logic [IDX_W-1:0]        scan_idx;

   logic [4*NUM_DIGITS-1:0] disp_value;
   logic [NUM_DIGITS-1:0]   disp_dp;
   logic                    disp_blz;

   logic [4*NUM_DIGITS-1:0] pend_value;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pend_blz;
   logic                    pend_valid;

   logic                    slot_end;
   logic                    frame_wrap;

   logic [3:0]              cur_nibble;
   logic                    cur_dp;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    cur_blank;
   logic                    in_guard;
   seg_t                    lut_seg;
   seg_t                    seg_int;
   logic [NUM_DIGITS-1:0]   an_int;

   assign slot_end   = ENABLE && (prescaler == PRE_LAST);
   assign frame_wrap = slot_end && (scan_idx == IDX_LAST);

   // Prescaler and scan position
   always_ff @(posedge CLK) begin
      if (RST) begin
         prescaler <= '0;
         scan_idx  <= '0;
      end else if (slot_end) begin
         prescaler <= '0;
         scan_idx  <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else if (ENABLE) begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Load path: data waits in the pending register until the frame wraps,
   // unless the strobe lands on the wrap edge itself, in which case it
   // goes straight to the display so the new frame starts with it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         disp_value <= '0;
         disp_dp    <= '0;
         disp_blz   <= 1'b0;
         pend_value <= '0;
         pend_dp    <= '0;
         pend_blz   <= 1'b0;
         pend_valid <= 1'b0;
      end else if (LOAD) begin
         if (frame_wrap) begin
            disp_value <= VALUE;
            disp_dp    <= DP_IN;
            disp_blz   <= BLANK_LZ;
            pend_valid <= 1'b0;
         end else begin
            pend_value <= VALUE;
            pend_dp    <= DP_IN;
            pend_blz   <= BLANK_LZ;
            pend_valid <= 1'b1;
         end
      end else if (frame_wrap && pend_valid) begin
         disp_value <= pend_value;
         disp_dp    <= pend_dp;
         disp_blz   <= pend_blz;
         pend_valid <= 1'b0;
      end
   end

   // Digit select and nibble/DP mux for the active digit
   always_comb begin
      cur_nibble = 4'h0;
      cur_dp     = 1'b0;
      an_sel     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (scan_idx == IDX_W'(i)) begin
            cur_nibble = disp_value[4*i +: 4];
            cur_dp     = disp_dp[i];
            an_sel[i]  = 1'b1;
         end
      end
   end

   // lz_mask[i] is set when digit i and every digit above it are zero.
   // Digit 0 is left out so a zero value still shows a single 0.
   always_comb begin : lz_scan
      logic zero_run;
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run   = zero_run & (disp_value[4*i +: 4] == 4'h0);
         lz_mask[i] = zero_run;
      end
   end

   hex_seg_lut u_lut (
      .nibble (cur_nibble),
      .seg    (lut_seg)
   );

   assign cur_blank = disp_blz && (|(lz_mask & an_sel));
   assign seg_int   = cur_blank ? SEG_BLANK : lut_seg;
   assign in_guard  = (prescaler < GUARD_END);
   assign an_int    = in_guard ? '0 : an_sel;

   // Output registers; the only place pin polarity is applied.
   always_ff @(posedge CLK) begin
      if (RST) begin
         SEV        <= SEG_OFF_PIN;
         DP         <= SEG_INV;
         AN         <= AN_OFF_PIN;
         DIGIT_IDX  <= '0;
         FRAME_DONE <= 1'b0;
      end else begin
         DIGIT_IDX  <= scan_idx;
         FRAME_DONE <= frame_wrap;
         if (ENABLE) begin
            SEV <= seg_int ^ SEG_OFF_PIN;
            DP  <= cur_dp ^ SEG_INV;
            AN  <= an_int ^ AN_OFF_PIN;
         end else begin
            SEV <= SEG_OFF_PIN;
            DP  <= SEG_INV;
            AN  <= AN_OFF_PIN;
         end
      end
   end

endmodule

// File: doc/sev_seg_scan_driver.md
Name: sev_seg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode/cathode seven-segment display.
- Latches a packed hex value and scans one digit per refresh slot, with per-digit decimal points, optional leading-zero blanking, anti-ghosting guard time and tear-free updates at frame boundaries.
- Sits between the calculator result path and the board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; range 1..8.
- REFRESH_DIV, 50000: CLK cycles per digit slot; must be ≥ 2.
- GUARD_CYCLES, 1: cycles at the start of each slot with all anodes inactive; must be < REFRESH_DIV.
- SEG_ACTIVE_LOW, 0: 1 inverts SEV and DP at the pins.
- AN_ACTIVE_LOW, 1: 1 means an anode is active when driven 0.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- ENABLE  in  1  scan enable.
- LOAD  in  1  single-cycle strobe; capture VALUE, DP_IN and BLANK_LZ.
- VALUE  in  4*NUM_DIGITS  packed nibbles; digit 0 is bits [3:0] and is the least significant.
- DP_IN  in  NUM_DIGITS  decimal point per digit; 1 = lit.
- BLANK_LZ  in  1  enable leading-zero blanking.
- SEV  out  [0:6]  segments a..g; a = index 0; 1 = lit before polarity.
- DP  out  1  decimal point of the active digit.
- AN  out  NUM_DIGITS  digit select, one-hot active.
- DIGIT_IDX  out  $clog2(NUM_DIGITS) (min 1)  digit currently driven.
- FRAME_DONE  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - prescaler=0, DIGIT_IDX=0, display and pending registers=0, pending flag=0.
  - AN all inactive, SEV and DP all unlit (at pin polarity), FRAME_DONE=0.
  - Reset mid-scan or while a load is pending discards everything.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while ENABLE=1.
  - At REFRESH_DIV-1 it returns to 0 and DIGIT_IDX advances.
  - DIGIT_IDX wraps from NUM_DIGITS-1 to 0; that wrap edge is the frame boundary.
- Load path:
  - LOAD=1 writes VALUE, DP_IN and BLANK_LZ to the pending register and sets the pending flag.
  - A later LOAD before the boundary overwrites the pending register (last write wins).
  - At the frame boundary, if the pending flag is set: display reg <= pending reg and the flag clears.
  - If LOAD coincides with the boundary cycle, the LOAD data goes straight to the display reg and the flag ends clear.
  - LOAD is accepted regardless of ENABLE. With ENABLE=0 no boundary occurs, so the data stays pending.
- Digit decode:
  - The nibble for DIGIT_IDX is selected from the display reg and mapped through the hex LUT.
  - Encodings, listed as a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Leading-zero blanking:
  - Applies when the latched BLANK_LZ=1.
  - Digit i (i>0) is blanked (SEV=0000000) if nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - DP still follows DP_IN on blanked digits.
- Guard time:
  - While prescaler < GUARD_CYCLES, all AN are inactive.
  - Otherwise only AN[DIGIT_IDX] is active.
- Output timing:
  - SEV, DP, AN, DIGIT_IDX and FRAME_DONE are registered: pins reflect the counter/display state of the previous cycle (1-cycle latency).
  - FRAME_DONE asserts in the cycle after the boundary edge.
- ENABLE=0:
  - Prescaler and DIGIT_IDX hold.
  - From the next edge, AN are all inactive and SEV/DP are unlit.
  - When ENABLE returns to 1, the scan resumes from the held state.
- Polarity: inversion is applied only at the output registers. Internal logic is always active-high.

Decomposition:
- Package sev_pkg:
  - seg_t = logic [0:6].
  - SEG_BLANK constant.
  - 16-entry hex-to-segment constant table.
  - Function hex2seg(nibble) returning seg_t.
- Sub-module hex_seg_lut: combinational, 4-bit nibble in, seg_t out, wraps hex2seg. Instantiated once on the muxed nibble.
- Prescaler, scan counter, load/pending logic and output registers live in sev_seg_scan_driver.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1):
- Reset then idle, ENABLE=1, no LOAD:
  - AN=1111 for one cycle after reset.
  - Then the scan runs AN 1110 → 1101 → 1011 → 0111, with a 1111 guard cycle at the start of each slot.
  - SEV=1111110 on every digit.
  - FRAME_DONE pulses every 16 cycles.
- LOAD VALUE=16'h1A3F, DP_IN=4'b0100, BLANK_LZ=0 mid-frame:
  - The remaining digits still show 0 until the boundary.
  - The next frame shows digit0=1000111, digit1=1111001, digit2=1110111 with DP=1, digit3=0110000.
- LOAD VALUE=16'h0007, BLANK_LZ=1:
  - Digits 3..1 give SEV=0000000; digit0 gives SEV=1110000.
  - Repeat with 16'h0000: digit0 gives SEV=1111110 and the others are blank.
- Two LOADs in one frame (16'h1111, then 16'h2222):
  - The next frame shows only 2 (1101101) on all digits; 1 never appears.
- LOAD 16'h5555 on the exact boundary cycle:
  - The following frame starts with 5 (1011011) immediately.
  - The pending flag is clear afterwards.
- ENABLE=0 for 10 cycles mid-slot, then ENABLE=1:
  - AN=1111 and SEV=0000000 throughout the disable.
  - DIGIT_IDX is unchanged and the scan resumes from the held count.
- Additionally, RST asserted mid-frame with a load pending:
  - All registers clear and the pending data is discarded.
